// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: two registered read ports, one general
// write port, ACC/ISZERO/IN side-write ports. Optional macro REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int ACC_IDX    = 0,
  parameter int IN_IDX     = 1,
  parameter int OUT_IDX    = 2,
  parameter int ISZERO_IDX = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] acc_data_in,
  input  logic              acc_write,
  input  logic [DATA_W-1:0] iszero_data,
  input  logic              iszero_write,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_data_write,
  output logic [DATA_W-1:0] read_data0,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] acc_data,
  output logic [DATA_W-1:0] out_data,
  output logic              wr_prot_err
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ACC_A = ADDR_W'(ACC_IDX);
  localparam logic [ADDR_W-1:0] ISZ_A = ADDR_W'(ISZERO_IDX);

  logic [DATA_W-1:0] regs      [DEPTH];
  logic [DATA_W-1:0] regs_next [DEPTH];
  logic [DATA_W-1:0] rd0_src;
  logic [DATA_W-1:0] rd1_src;
  logic              prot_hit;
  logic              gen_we;

  assign prot_hit = reg_write && ((wa == ACC_A) || (wa == ISZ_A));
  assign gen_we   = reg_write && !prot_hit;

  // Side writes are applied after the general write so they win a collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: every element gets its current value first, so no path leaves it unassigned (no latch).
      regs_next[i] = regs[i];
      if (gen_we && (wa == ADDR_W'(i))) regs_next[i] = write_data;
      if (in_data_write && (i == IN_IDX)) regs_next[i] = in_data;
      if (acc_write && (i == ACC_IDX)) regs_next[i] = acc_data_in;
      if (iszero_write && (i == ISZERO_IDX)) regs_next[i] = iszero_data;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign rd0_src = regs_next[ra0];
  assign rd1_src = regs_next[ra1];
`else
  assign rd0_src = regs[ra0];
  assign rd1_src = regs[ra1];
`endif

  assign acc_data = regs[ACC_IDX];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the whole array is reset because software relies on every register reading zero after reset.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      read_data0  <= '0;
      read_data1  <= '0;
      out_data    <= '0;
      wr_prot_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int i = 0; i < DEPTH; i++) regs[i] <= regs_next[i];
      read_data0  <= rd0_src;
      read_data1  <= rd1_src;
      out_data    <= regs_next[OUT_IDX];
      wr_prot_err <= prot_hit;
    end
  end

endmodule
